// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared state type, constants and sizing helper for the sequential divider
package seq_divider_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [63:0] DIV_BY_ZERO_Q = '1;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seq_divider_div_restore_step.sv
// div_restore_step: one combinational restoring-division step (shift in a bit, compare, conditionally subtract)
module div_restore_step #(
  parameter int DEN_W = 4
) (
  input  logic [DEN_W-1:0] rem_in,
  input  logic             bit_in,
  input  logic [DEN_W-1:0] den,
  output logic [DEN_W-1:0] rem_out,
  output logic             q_bit
);
  logic [DEN_W:0] sh;
  always_comb begin
    sh = {rem_in, bit_in};
    q_bit = sh >= {1'b0, den};
    rem_out = DEN_W'(q_bit ? sh - {1'b0, den} : sh);
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider producing one quotient bit per clock behind valid/ready handshakes
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int NUM_W         = 6,
  parameter int DEN_W         = 4,
  parameter bit USE_CONST_DIV = 1'b1,
  parameter int CONST_DIVISOR = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NUM_W-1:0] numerator,
  input  logic [DEN_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NUM_W-1:0] quotient,
  output logic [DEN_W-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = cnt_w(NUM_W);
  state_t state, state_nx;
  logic [NUM_W-1:0] num_sh;
  logic [DEN_W-1:0] den, rem, rem_nx, eff_den;
  logic [CW-1:0] cnt;
  logic q_bit, accept, zero, last;
  div_restore_step #(.DEN_W(DEN_W)) u_step (
    .rem_in (rem),
    .bit_in (num_sh[NUM_W-1]),
    .den    (den),
    .rem_out(rem_nx),
    .q_bit  (q_bit)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    eff_den = USE_CONST_DIV ? DEN_W'(CONST_DIVISOR) : divisor;
    accept = in_valid && state == IDLE;
    zero = eff_den == '0;
    last = cnt == '0;
    state_nx = state == IDLE ? (accept ? (zero ? DONE : CALC) : IDLE)
             : state == CALC ? (last ? DONE : CALC)
             : (out_ready ? IDLE : DONE);
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      num_sh <= '0;
      den <= '0;
      rem <= '0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      num_sh <= numerator;
      den <= eff_den;
      rem <= '0;
      cnt <= CW'(NUM_W - 1);
      if (zero) begin
        quotient <= DIV_BY_ZERO_Q[NUM_W-1:0];
        remainder <= '0;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      num_sh <= {num_sh[NUM_W-2:0], q_bit};
      rem <= rem_nx;
      cnt <= cnt - CW'(1);
      if (last) begin
        quotient <= {num_sh[NUM_W-2:0], q_bit};
        remainder <= rem_nx;
        div_by_zero <= 1'b0;
      end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench covering constant, runtime and zero-divisor configurations
module tb_seq_divider;
  typedef struct {logic [7:0] q; logic [3:0] r; logic z;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic c_iv = 0, c_ir, c_ov, c_or = 0, c_z;
  logic [5:0] c_num = 0, c_q;
  logic [3:0] c_div = 0, c_r;
  logic r_iv = 0, r_ir, r_ov, r_or = 0, r_z;
  logic [7:0] r_num = 0, r_q;
  logic [3:0] r_div = 0, r_r;
  logic z_iv = 0, z_ir, z_ov, z_or = 0, z_z;
  logic [5:0] z_num = 0, z_q;
  logic [3:0] z_div = 0, z_r;
  exp_t c_sb[$], r_sb[$], z_sb[$];
  exp_t e;
  int n_cmp = 0;
  int n_bad = 0;
  int ed;
  seq_divider c_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .numerator(c_num), .divisor(c_div),
    .out_valid(c_ov), .out_ready(c_or), .quotient(c_q), .remainder(c_r), .div_by_zero(c_z)
  );
  seq_divider #(.NUM_W(8), .DEN_W(4), .USE_CONST_DIV(1'b0), .CONST_DIVISOR(12)) r_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(r_iv), .in_ready(r_ir), .numerator(r_num), .divisor(r_div),
    .out_valid(r_ov), .out_ready(r_or), .quotient(r_q), .remainder(r_r), .div_by_zero(r_z)
  );
  seq_divider #(.NUM_W(6), .DEN_W(4), .USE_CONST_DIV(1'b0), .CONST_DIVISOR(12)) z_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(z_iv), .in_ready(z_ir), .numerator(z_num), .divisor(z_div),
    .out_valid(z_ov), .out_ready(z_or), .quotient(z_q), .remainder(z_r), .div_by_zero(z_z)
  );
  function automatic logic ov_of(input int which);
    return which == 0 ? c_ov : which == 1 ? r_ov : z_ov;
  endfunction
  task automatic wait_ov(input int which, output int edges);
    edges = 0;
    while (!ov_of(which) && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    if (!ov_of(which)) edges = -1;
  endtask
  task automatic c_send(input logic [5:0] n);
    exp_t x;
    x.q = 8'(n / 12);
    x.r = 4'(n % 12);
    x.z = 1'b0;
    c_sb.push_back(x);
    c_num = n;
    c_iv = 1'b1;
    @(negedge clk);
    c_iv = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({c_ir, c_ov, c_q, c_r, c_z} !== {1'b1, 1'b0, 6'd0, 4'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_c: got ir=%b ov=%b q=%0d r=%0d z=%b expected ir=1 ov=0 q=0 r=0 z=0", c_ir, c_ov, c_q, c_r, c_z);
    end
    n_cmp++;
    if ({r_ir, r_ov, r_q, r_r, r_z} !== {1'b1, 1'b0, 8'd0, 4'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_r: got ir=%b ov=%b q=%0d r=%0d z=%b expected ir=1 ov=0 q=0 r=0 z=0", r_ir, r_ov, r_q, r_r, r_z);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_latency;
    c_send(6'd63);
    n_cmp++;
    if ({c_ir, c_ov} !== 2'b00) begin
      n_bad++;
      $display("FAIL lat_e0: got ir=%b ov=%b expected ir=0 ov=0", c_ir, c_ov);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({c_ir, c_ov} !== {1'b0, 1'(k == 6)}) begin
        n_bad++;
        $display("FAIL lat_edge%0d: got ir=%b ov=%b expected ir=0 ov=%b", k, c_ir, c_ov, k == 6);
      end
    end
    e = c_sb.pop_front();
    n_cmp++;
    if ({c_q, c_r, c_z} !== {e.q[5:0], e.r, e.z}) begin
      n_bad++;
      $display("FAIL lat_result: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b", c_q, c_r, c_z, e.q, e.r, e.z);
    end
    c_or = 1'b1;
    @(negedge clk);
    c_or = 1'b0;
    n_cmp++;
    if ({c_ir, c_ov} !== 2'b10) begin
      n_bad++;
      $display("FAIL lat_release: got ir=%b ov=%b expected ir=1 ov=0", c_ir, c_ov);
    end
  endtask
  task automatic test_sweep;
    c_or = 1'b1;
    for (int n = 0; n < 64; n++) begin
      c_send(6'(n));
      wait_ov(0, ed);
      n_cmp++;
      if (ed != 6) begin
        n_bad++;
        $display("FAIL sweep_lat n=%0d: got %0d edges expected 6", n, ed);
      end
      e = c_sb.pop_front();
      n_cmp++;
      if ({c_q, c_r, c_z} !== {e.q[5:0], e.r, e.z}) begin
        n_bad++;
        $display("FAIL sweep n=%0d: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b", n, c_q, c_r, c_z, e.q, e.r, e.z);
      end
      @(negedge clk);
      n_cmp++;
      if (c_ir !== 1'b1) begin
        n_bad++;
        $display("FAIL sweep_ready n=%0d: got ir=%b expected 1", n, c_ir);
      end
    end
    c_or = 1'b0;
  endtask
  task automatic test_runtime;
    int tn[7] = '{200, 5, 173, 255, 0, 15, 99};
    int td[7] = '{7, 9, 1, 15, 5, 15, 10};
    exp_t x;
    r_or = 1'b1;
    for (int i = 0; i < 7; i++) begin
      x.q = 8'(tn[i] / td[i]);
      x.r = 4'(tn[i] % td[i]);
      x.z = 1'b0;
      r_sb.push_back(x);
      r_num = 8'(tn[i]);
      r_div = 4'(td[i]);
      r_iv = 1'b1;
      @(negedge clk);
      r_iv = 1'b0;
      r_div = 4'd3;
      r_num = 8'hAA;
      wait_ov(1, ed);
      n_cmp++;
      if (ed != 8) begin
        n_bad++;
        $display("FAIL rt_lat %0d/%0d: got %0d edges expected 8", tn[i], td[i], ed);
      end
      e = r_sb.pop_front();
      n_cmp++;
      if ({r_q, r_r, r_z} !== {e.q, e.r, e.z}) begin
        n_bad++;
        $display("FAIL rt %0d/%0d: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b", tn[i], td[i], r_q, r_r, r_z, e.q, e.r, e.z);
      end
      @(negedge clk);
    end
    r_or = 1'b0;
  endtask
  task automatic test_div_zero;
    exp_t x;
    x.q = 8'd63;
    x.r = 4'd0;
    x.z = 1'b1;
    z_sb.push_back(x);
    z_num = 6'd20;
    z_div = 4'd0;
    z_iv = 1'b1;
    @(negedge clk);
    z_iv = 1'b0;
    n_cmp++;
    if ({z_ir, z_ov} !== 2'b01) begin
      n_bad++;
      $display("FAIL dz_done: got ir=%b ov=%b expected ir=0 ov=1", z_ir, z_ov);
    end
    e = z_sb.pop_front();
    n_cmp++;
    if ({z_q, z_r, z_z} !== {e.q[5:0], e.r, e.z}) begin
      n_bad++;
      $display("FAIL dz_result: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b", z_q, z_r, z_z, e.q, e.r, e.z);
    end
    z_or = 1'b1;
    @(negedge clk);
    z_or = 1'b0;
    x.q = 8'd6;
    x.r = 4'd2;
    x.z = 1'b0;
    z_sb.push_back(x);
    z_div = 4'd3;
    z_iv = 1'b1;
    @(negedge clk);
    z_iv = 1'b0;
    wait_ov(2, ed);
    n_cmp++;
    if (ed != 6) begin
      n_bad++;
      $display("FAIL dz_next_lat: got %0d edges expected 6", ed);
    end
    e = z_sb.pop_front();
    n_cmp++;
    if ({z_q, z_r, z_z} !== {e.q[5:0], e.r, e.z}) begin
      n_bad++;
      $display("FAIL dz_next: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b", z_q, z_r, z_z, e.q, e.r, e.z);
    end
    z_or = 1'b1;
    @(negedge clk);
    z_or = 1'b0;
  endtask
  task automatic test_backpressure;
    c_send(6'd30);
    wait_ov(0, ed);
    n_cmp++;
    if (ed != 6) begin
      n_bad++;
      $display("FAIL bp_lat: got %0d edges expected 6", ed);
    end
    e = c_sb.pop_front();
    c_num = 6'd50;
    c_iv = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({c_ir, c_ov, c_q, c_r, c_z} !== {1'b0, 1'b1, e.q[5:0], e.r, e.z}) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got ir=%b ov=%b q=%0d r=%0d z=%b expected ir=0 ov=1 q=%0d r=%0d z=%b", k, c_ir, c_ov, c_q, c_r, c_z, e.q, e.r, e.z);
      end
      @(negedge clk);
    end
    c_sb.push_back('{8'd4, 4'd2, 1'b0});
    c_or = 1'b1;
    @(negedge clk);
    c_or = 1'b0;
    n_cmp++;
    if ({c_ir, c_ov} !== 2'b10) begin
      n_bad++;
      $display("FAIL bp_release: got ir=%b ov=%b expected ir=1 ov=0", c_ir, c_ov);
    end
    @(negedge clk);
    c_iv = 1'b0;
    wait_ov(0, ed);
    n_cmp++;
    if (ed != 6) begin
      n_bad++;
      $display("FAIL bp_next_lat: got %0d edges expected 6", ed);
    end
    e = c_sb.pop_front();
    n_cmp++;
    if ({c_q, c_r, c_z} !== {e.q[5:0], e.r, e.z}) begin
      n_bad++;
      $display("FAIL bp_next: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b", c_q, c_r, c_z, e.q, e.r, e.z);
    end
    c_or = 1'b1;
    @(negedge clk);
    c_or = 1'b0;
  endtask
  task automatic test_reset_mid;
    logic seen;
    c_send(6'd40);
    c_sb.delete();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({c_ir, c_ov, c_q, c_r, c_z} !== {1'b1, 1'b0, 6'd0, 4'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL mid_reset: got ir=%b ov=%b q=%0d r=%0d z=%b expected ir=1 ov=0 q=0 r=0 z=0", c_ir, c_ov, c_q, c_r, c_z);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seen = seen | c_ov;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_no_valid: got ov=%b after abort expected 0", seen);
    end
    c_send(6'd25);
    wait_ov(0, ed);
    n_cmp++;
    if (ed != 6) begin
      n_bad++;
      $display("FAIL mid_next_lat: got %0d edges expected 6", ed);
    end
    e = c_sb.pop_front();
    n_cmp++;
    if ({c_q, c_r, c_z} !== {e.q[5:0], e.r, e.z}) begin
      n_bad++;
      $display("FAIL mid_next: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b", c_q, c_r, c_z, e.q, e.r, e.z);
    end
    c_or = 1'b1;
    @(negedge clk);
    c_or = 1'b0;
  endtask
  initial begin
    test_reset;
    test_latency;
    test_sweep;
    test_runtime;
    test_div_zero;
    test_backpressure;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised iterative restoring divider; successor to the fixed combinational divide-by-12 lookup used for note/octave and grid-cell arithmetic.
- Accepts an unsigned NUM_W-bit numerator and a DEN_W-bit divisor, which is either the runtime port or a build-time constant.
- Produces quotient and remainder one bit per clock, using a valid/ready handshake on both sides.
- Feeds score/sound and board-coordinate logic, where a shared multi-cycle divider replaces per-constant lookup tables.

Parameters:
- NUM_W, 6: numerator and quotient width; must be >= DEN_W.
- DEN_W, 4: divisor and remainder width.
- USE_CONST_DIV, 1: 1 = use CONST_DIVISOR and ignore the divisor port; 0 = use the divisor port.
- CONST_DIVISOR, 12: fixed divisor when USE_CONST_DIV=1; must be nonzero and fit in DEN_W.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: numerator/divisor valid.
- in_ready, output, 1: block can accept; high only in IDLE.
- numerator, input, NUM_W: dividend, unsigned.
- divisor, input, DEN_W: divisor, unsigned; ignored when USE_CONST_DIV=1.
- out_valid, output, 1: result valid; held until consumed.
- out_ready, input, 1: consumer accepts result.
- quotient, output, NUM_W: numerator / divisor.
- remainder, output, DEN_W: numerator mod divisor.
- div_by_zero, output, 1: result came from a zero divisor.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - CALC: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Reset (asynchronous, rst_n=0): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, bit counter=0, working registers=0.
- Acceptance (edge E0): in_valid & in_ready sampled high in IDLE.
  - Latch numerator into the shift register.
  - Latch the effective divisor (the port, or CONST_DIVISOR).
  - Clear the partial remainder (DEN_W+1 bits).
  - Load counter = NUM_W-1; go to CALC.
- Zero divisor at acceptance (runtime mode only):
  - Skip CALC and go directly to DONE at E0.
  - quotient = all ones, remainder = 0, div_by_zero = 1.
- Each CALC edge performs one restoring step, MSB first:
  - r = {r[DEN_W-1:0], next numerator bit}.
  - If r >= d: r = r - d and the quotient bit is 1; otherwise the quotient bit is 0.
  - The counter decrements. The edge where counter==0 finishes the last step, writes quotient/remainder, sets div_by_zero=0 and enters DONE.
- Latency: out_valid rises exactly NUM_W edges after E0 (6 for the defaults). Throughput is one result per NUM_W+2 cycles minimum.
- DONE:
  - quotient, remainder and div_by_zero are stable while out_valid=1 and out_ready=0, for any number of cycles.
  - out_valid & out_ready returns the block to IDLE on that edge.
- Outputs keep their last values in IDLE/CALC, but are valid only while out_valid=1.
- in_valid is ignored outside IDLE; no queuing, no drop flag. The upstream holds in_valid until in_ready.
- numerator and divisor are sampled only at E0; later changes have no effect on the result in flight.
- Arithmetic:
  - The remainder is always < d. The compare uses DEN_W+1 bits, so there is no overflow.
  - numerator=0 gives q=0, r=0.
  - numerator < d gives q=0, r=numerator.
  - d=1 gives q=numerator, r=0.
- Reset mid-CALC or mid-DONE aborts immediately; no partial result is ever flagged valid.
- No combinational path from any input to any output: in_ready and out_valid decode from the state register only.

Decomposition:
- Shared package:
  - State enum {IDLE, CALC, DONE}.
  - Counter-width constant, clog2(NUM_W).
  - Constant DIV_BY_ZERO_Q = all ones.
- One sub-module, div_restore_step: combinational.
  - Inputs: partial remainder, incoming bit, divisor.
  - Outputs: next partial remainder and quotient bit.
  - Instantiated once in the datapath.

Test Plan:
- Defaults, numerator=63 -> q=5, r=3, div_by_zero=0; out_valid rises exactly 6 edges after acceptance; in_ready=0 throughout.
- Defaults, sweep numerator 0..63 with out_ready=1 -> every result matches n/12 and n%12 (e.g. 12 -> q=1 r=0; 47 -> q=3 r=11); in_ready returns 1 the cycle after each handshake.
- USE_CONST_DIV=0, NUM_W=8, DEN_W=4, numerator=200, divisor=7 -> q=28, r=4 after 8 edges; divisor port changed to 3 during CALC does not alter the result.
- USE_CONST_DIV=0, numerator=20, divisor=0 -> DONE on the accepting edge; q=63, r=0, div_by_zero=1.
- Backpressure: out_ready held low 5 cycles in DONE -> q/r/div_by_zero stable and in_ready=0; a new in_valid during that time is not accepted until after out_ready.
- Assert rst_n=0 at CALC edge 3 -> asynchronously all outputs reset, in_ready=1, out_valid=0; the next request 25/12 gives q=2, r=1 normally.
